// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for fp_mul_seq.
// master: the side that supplies operands and consumes results.
// slave: the multiplier.
interface fp_mul_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;

    modport master (
        output in_valid, a1, b1, out_ready,
        input  in_ready, out_valid, c
    );

    modport slave (
        input  in_valid, a1, b1, out_ready,
        output in_ready, out_valid, c
    );
endinterface

// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier.
// The 24x24 mantissa product is formed by 24-cycle shift-and-add, then normalized in one cycle.
// There is no NaN/Inf/denormal handling, and exponent arithmetic wraps modulo 256.
// Define FP_MUL_ROUND_EN for round-to-nearest-even. Otherwise the result is truncated.
module fp_mul_seq (
    input  logic         clk,
    input  logic         rst_n,
    fp_mul_seq_if.slave  bus_io
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StNorm = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        sign_q, sign_d;
    logic [7:0]  ea_q, ea_d, eb_q, eb_d;
    logic [23:0] ma_q, ma_d, mb_q, mb_d;
    logic        z_q, z_d;
    logic [47:0] p_q, p_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] c_q, c_d;

    logic [22:0] frac;
    logic [7:0]  ec;

    // Normalize the finished product and build the packed exponent/fraction.
`ifdef FP_MUL_ROUND_EN
    logic        guard, sticky;
    logic [23:0] frac_inc;
    always_comb begin
        if (p_q[47]) begin
            frac   = p_q[46:24];
            guard  = p_q[23];
            sticky = |p_q[22:0];
        end else begin
            frac   = p_q[45:23];
            guard  = p_q[22];
            sticky = |p_q[21:0];
        end
        // 129 == -127 mod 256
        ec       = ea_q + eb_q + 8'd129 + {7'd0, p_q[47]};
        frac_inc = {1'b0, frac} + 24'd1;
        if (guard && (sticky || frac[0])) begin
            if (frac_inc[23]) begin
                frac = 23'd0;
                ec   = ec + 8'd1;
            end else begin
                frac = frac_inc[22:0];
            end
        end
    end
`else
    logic unused_round_bits;
    assign unused_round_bits = ^p_q[22:0];
    always_comb begin
        frac = p_q[47] ? p_q[46:24] : p_q[45:23];
        // 129 == -127 mod 256
        ec   = ea_q + eb_q + 8'd129 + {7'd0, p_q[47]};
    end
`endif

    // Next-state logic for the accept / multiply / normalize / hold sequence.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        z_d         = z_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        c_d         = c_q;
        case (state_q)
            StIdle: begin
                if (bus_io.in_valid && in_ready_q) begin
                    sign_d     = bus_io.a1[31] ^ bus_io.b1[31];
                    ea_d       = bus_io.a1[30:23];
                    eb_d       = bus_io.b1[30:23];
                    ma_d       = {1'b1, bus_io.a1[22:0]};
                    mb_d       = {1'b1, bus_io.b1[22:0]};
                    z_d        = (bus_io.a1[30:0] == 31'd0) || (bus_io.b1[30:0] == 31'd0);
                    p_d        = 48'd0;
                    cnt_d      = 5'd0;
                    in_ready_d = 1'b0;
                    state_d    = StMul;
                end
            end
            StMul: begin
                // Multiplier bits are consumed LSB first.
                if (mb_q[cnt_q]) begin
                    p_d = p_q + ({24'd0, ma_q} << cnt_q);
                end
                if (cnt_q == 5'd23) begin
                    cnt_d   = 5'd0;
                    state_d = StNorm;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StNorm: begin
                c_d         = z_q ? {sign_q, 31'd0} : {sign_q, ec, frac};
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            default: begin
                if (out_valid_q && bus_io.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    // State registers. An async reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sign_q      <= 1'b0;
            ea_q        <= 8'd0;
            eb_q        <= 8'd0;
            ma_q        <= 24'd0;
            mb_q        <= 24'd0;
            z_q         <= 1'b0;
            p_q         <= 48'd0;
            cnt_q       <= 5'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            c_q         <= 32'd0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            z_q         <= z_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
        end
    end

    assign bus_io.in_ready  = in_ready_q;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.c         = c_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed self-checking bench for fp_mul_seq.
module tb_fp_mul_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fp_mul_seq_if bus ();

    fp_mul_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation.
    // Returns the in_ready value after the accept edge, the number of edges from accept to
    // out_valid, and the result. The output handshake is left pending.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                          output int lat, output logic rdy_after);
        bus.a1       = a;
        bus.b1       = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rdy_after    = bus.in_ready;
        lat          = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.c;
    endtask

    task automatic take_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.c !== 32'h0) begin
            errors++;
            $display("FAIL reset_c: got %h want 00000000", bus.c);
        end
    endtask

    task automatic test_basic();
        logic [31:0] res;
        int          lat;
        logic        rdy;
        run_op(32'h40000000, 32'h40400000, res, lat, rdy);
        checks++;
        if (rdy !== 1'b0) begin
            errors++;
            $display("FAIL basic_in_ready_drop: got %b want 0", rdy);
        end
        checks++;
        if (lat != 25) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 25", lat);
        end
        checks++;
        if (res !== 32'h40C00000) begin
            errors++;
            $display("FAIL basic_2x3: got %h want 40c00000", res);
        end
        take_result();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_handshake: got ov=%b ir=%b want ov=0 ir=1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_sign_norm();
        logic [31:0] res;
        int          lat;
        logic        rdy;
        run_op(32'h3FC00000, 32'hBFC00000, res, lat, rdy);
        checks++;
        if (res !== 32'hC0100000) begin
            errors++;
            $display("FAIL sign_norm_1p5xm1p5: got %h want c0100000", res);
        end
        take_result();
    endtask

    task automatic test_zero();
        logic [31:0] res;
        int          lat;
        logic        rdy;
        run_op(32'h00000000, 32'h40490FDB, res, lat, rdy);
        checks++;
        if (res !== 32'h00000000 || lat != 25) begin
            errors++;
            $display("FAIL zero_pos: got c=%h lat=%0d want c=00000000 lat=25", res, lat);
        end
        take_result();
        run_op(32'h80000000, 32'h3F800000, res, lat, rdy);
        checks++;
        if (res !== 32'h80000000 || lat != 25) begin
            errors++;
            $display("FAIL zero_neg: got c=%h lat=%0d want c=80000000 lat=25", res, lat);
        end
        take_result();
    endtask

    task automatic test_round();
        logic [31:0] res;
        int          lat;
        logic        rdy;
        logic [31:0] want;
`ifdef FP_MUL_ROUND_EN
        want = 32'h40100002;
`else
        want = 32'h40100001;
`endif
        run_op(32'h3FC00001, 32'h3FC00001, res, lat, rdy);
        checks++;
        if (res !== want) begin
            errors++;
            $display("FAIL round_guard_sticky: got %h want %h", res, want);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int          lat;
        logic        rdy;
        int          bad;
        // 1.0 x 2.0
        run_op(32'h3F800000, 32'h40000000, res, lat, rdy);
        checks++;
        if (res !== 32'h40000000) begin
            errors++;
            $display("FAIL bp_result: got %h want 40000000", res);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.c !== 32'h40000000 || bus.in_ready !== 1'b0) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        take_result();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got ov=%b ir=%b want ov=0 ir=1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        logic        rdy;
        int          seen;
        bus.a1       = 32'h40000000;
        bus.b1       = 32'h40400000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.c !== 32'h0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got ov=%b c=%h ir=%b want ov=0 c=00000000 ir=1",
                     bus.out_valid, bus.c, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_no_output: got %0d valid cycles want 0", seen);
        end
        run_op(32'h40000000, 32'h40400000, res, lat, rdy);
        checks++;
        if (res !== 32'h40C00000 || lat != 25) begin
            errors++;
            $display("FAIL after_reset_2x3: got c=%h lat=%0d want c=40c00000 lat=25", res, lat);
        end
        take_result();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a1        = 32'h0;
        bus.b1        = 32'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_sign_norm();
        test_zero();
        test_round();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
